// File: rtl/fifo_rd_drain_pkg.sv
// Shared definitions for the FIFO read-side drain engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_drain_pkg;

  // Drain FSM encoding; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The output buffer holds two entries, so its occupancy (0..2) needs two bits.
  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer; head entry is presented combinationally on head_data.
// Latency: a push into an empty buffer is visible on head_data the next cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: rclk/rrst_n clock and async reset, push/push_data write side,
//        pop (head consumed), head_data current head, occ occupancy 0..2.
module fifo_skid_buf
  import fifo_rd_drain_pkg::*;
#(
  parameter int W = 9
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [OCC_W-1:0] occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         do_pop;
  logic         do_push;

  // Guard both sides so a stray pop on empty or push on full cannot corrupt state.
  assign do_pop    = pop && (occ != '0);
  assign do_push   = push && ((occ < OCC_W'(BUF_DEPTH)) || do_pop);
  assign head_data = ent0;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == '0) ent0 <= push_data;
          else           ent1 <= push_data;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - OCC_W'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (occ == OCC_W'(1)) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream in BURST_LEN bursts.
// Latency: one cycle from rinc to m_valid when the output buffer is empty.
// Backpressure: m_ready low fills the 2-entry buffer, after which rinc stops.
// Ports: rclk/rrst_n clock and async reset; en drain enable; rempty/rdata/rinc
//        FIFO read side; m_data/m_valid/m_ready/m_last stream; busy (not IDLE);
//        beat_cnt saturating count of accepted beats.
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      beat_cnt
);

  localparam int            CW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] PCNT_MAX = CW'(BURST_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    pcnt;
  logic [OCC_W-1:0] occ;
  logic [DSIZE:0]   head;
  logic             space;
  logic             pop_state;
  logic             last_word;
  logic             accept;

  // A full buffer still has room when the head leaves in the same cycle.
  assign space     = (occ < OCC_W'(BUF_DEPTH)) || m_ready;
  // FLUSH only pops while a burst is open, so a boundary stops the drain.
  assign pop_state = (state == RUN) || ((state == FLUSH) && (pcnt != '0));
  assign rinc      = !rempty && pop_state && space;
  assign last_word = (pcnt == PCNT_MAX);

  assign m_valid = (occ != '0);
  assign m_last  = head[DSIZE];
  assign m_data  = head[DSIZE-1:0];
  assign accept  = m_valid && m_ready;
  assign busy    = (state != IDLE);

  fifo_skid_buf #(
    .W(DSIZE + 1)
  ) u_buf (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .push      (rinc),
    .push_data ({last_word, rdata}),
    .pop       (accept),
    .head_data (head),
    .occ       (occ)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = FLUSH;
      FLUSH: begin
        if (en)                                  state_nxt = RUN;
        else if ((pcnt == '0) && (occ == '0))    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop counter only moves on an actual pop, so an empty FIFO stalls it in place.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pcnt <= '0;
    end else if (rinc) begin
      pcnt <= last_word ? '0 : pcnt + CW'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt <= '0;
    end else if (accept && (beat_cnt != 16'hFFFF)) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        en;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] beat_cnt;

  fifo_rd_drain #(.DSIZE(8), .BURST_LEN(4)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .en       (en),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 rclk = ~rclk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] acc_d[$];
  logic       acc_l[$];
  int         acc_c[$];
  int         cyc = 0;
  int         rinc_cnt = 0;
  int         bad_rinc = 0;

  logic        s_rinc, s_valid, s_last, s_busy;
  logic [7:0]  s_data;
  logic [15:0] s_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
    refresh();
  endtask

  task automatic clear_stats();
    acc_d.delete();
    acc_l.delete();
    acc_c.delete();
    rinc_cnt = 0;
  endtask

  // One clock cycle: sample outputs at the falling edge, then model the FIFO pop.
  task automatic tick();
    logic [7:0] tmp;
    @(negedge rclk);
    s_rinc  = rinc;
    s_valid = m_valid;
    s_data  = m_data;
    s_last  = m_last;
    s_busy  = busy;
    s_beat  = beat_cnt;
    if (rinc) rinc_cnt++;
    if (rinc && rempty) bad_rinc++;
    if (m_valid && m_ready) begin
      acc_d.push_back(m_data);
      acc_l.push_back(m_last);
      acc_c.push_back(cyc);
    end
    @(posedge rclk);
    #1;
    if (s_rinc && fq.size() > 0) tmp = fq.pop_front();
    refresh();
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset for one cycle, preload the FIFO, then release with en=1.
  task automatic start(input int base, input int n, input logic ready);
    rrst_n  = 1'b0;
    en      = 1'b0;
    m_ready = ready;
    fq.delete();
    refresh();
    tick();
    load(base, n);
    clear_stats();
    en     = 1'b1;
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n  = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    fq.delete();
    load(10, 4);

    // Reset dominates a non-empty FIFO and en=1.
    tick();
    chk("rst_rinc", 32'(s_rinc), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_beat", 32'(s_beat), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_data", 32'(s_data), 0);
    chk("rst_last", 32'(s_last), 0);

    // Basic four-word burst at full rate.
    clear_stats();
    rrst_n = 1'b1;
    ticks(8);
    chk("b_cnt", 32'(acc_d.size()), 4);
    chk("b_d0", 32'(acc_d[0]), 10);
    chk("b_d1", 32'(acc_d[1]), 11);
    chk("b_d2", 32'(acc_d[2]), 12);
    chk("b_d3", 32'(acc_d[3]), 13);
    chk("b_l0", 32'(acc_l[0]), 0);
    chk("b_l2", 32'(acc_l[2]), 0);
    chk("b_l3", 32'(acc_l[3]), 1);
    chk("b_span", 32'(acc_c[3] - acc_c[0]), 3);
    chk("b_beat", 32'(s_beat), 4);
    chk("b_rinc", 32'(rinc_cnt), 4);

    // Sink stalled for five cycles: buffer fills after two pops and holds.
    start(10, 4, 1'b0);
    ticks(5);
    chk("st_rinc", 32'(rinc_cnt), 2);
    chk("st_valid", 32'(s_valid), 1);
    chk("st_data", 32'(s_data), 10);
    chk("st_last", 32'(s_last), 0);
    chk("st_acc", 32'(acc_d.size()), 0);
    m_ready = 1'b1;
    ticks(8);
    chk("st_cnt", 32'(acc_d.size()), 4);
    chk("st_d0", 32'(acc_d[0]), 10);
    chk("st_d1", 32'(acc_d[1]), 11);
    chk("st_d2", 32'(acc_d[2]), 12);
    chk("st_d3", 32'(acc_d[3]), 13);
    chk("st_l3", 32'(acc_l[3]), 1);
    chk("st_l1", 32'(acc_l[1]), 0);
    chk("st_beat", 32'(s_beat), 4);

    // en dropped after two pops: burst completes, then drain stops.
    start(20, 8, 1'b1);
    ticks(3);
    chk("fl_pre", 32'(rinc_cnt), 2);
    en = 1'b0;
    rinc_cnt = 0;
    ticks(8);
    chk("fl_rinc", 32'(rinc_cnt), 2);
    chk("fl_cnt", 32'(acc_d.size()), 4);
    chk("fl_d3", 32'(acc_d[3]), 23);
    chk("fl_l3", 32'(acc_l[3]), 1);
    chk("fl_l2", 32'(acc_l[2]), 0);
    chk("fl_busy", 32'(s_busy), 0);
    chk("fl_rinc_end", 32'(s_rinc), 0);

    // FIFO runs dry after word 2, refilled six cycles later.
    bad_rinc = 0;
    start(30, 2, 1'b1);
    ticks(3);
    ticks(6);
    chk("em_busy", 32'(s_busy), 1);
    chk("em_mid", 32'(acc_d.size()), 2);
    load(32, 4);
    ticks(10);
    chk("em_cnt", 32'(acc_d.size()), 6);
    chk("em_d2", 32'(acc_d[2]), 32);
    chk("em_l1", 32'(acc_l[1]), 0);
    chk("em_l2", 32'(acc_l[2]), 0);
    chk("em_l3", 32'(acc_l[3]), 1);
    chk("em_l4", 32'(acc_l[4]), 0);
    chk("em_d5", 32'(acc_d[5]), 35);
    chk("em_bad", 32'(bad_rinc), 0);

    // Reset pulse with a full buffer discards it; next burst restarts at count 0.
    start(40, 10, 1'b0);
    ticks(4);
    chk("rr_rinc", 32'(rinc_cnt), 2);
    chk("rr_valid", 32'(s_valid), 1);
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("rr_valid0", 32'(s_valid), 0);
    chk("rr_rinc0", 32'(s_rinc), 0);
    chk("rr_beat0", 32'(s_beat), 0);
    rrst_n = 1'b1;
    clear_stats();
    ticks(8);
    chk("rr_d0", 32'(acc_d[0]), 42);
    chk("rr_d3", 32'(acc_d[3]), 45);
    chk("rr_l0", 32'(acc_l[0]), 0);
    chk("rr_l2", 32'(acc_l[2]), 0);
    chk("rr_l3", 32'(acc_l[3]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
